// File: rtl/reg_file_mp.sv
// Two-write / two-read register file with per-entry valid bits, optional write-to-read
// forwarding, an optional hardwired-zero r0, and a one-entry-per-cycle clear sweep.
module reg_file_mp #(
    parameter int W       = 8,
    parameter int A       = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we0_i,
    input  logic         we1_i,
    input  logic [A-1:0] waddr0_i,
    input  logic [A-1:0] waddr1_i,
    input  logic [W-1:0] wdata0_i,
    input  logic [W-1:0] wdata1_i,
    input  logic [A-1:0] raddr0_i,
    input  logic [A-1:0] raddr1_i,
    output logic [W-1:0] rdata0_o,
    output logic [W-1:0] rdata1_o,
    output logic         rvalid0_o,
    output logic         rvalid1_o,
    input  logic         clear_i,
    output logic         busy_o,
    output logic         werr_o
);
    localparam int N = 2 ** A;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   cnt_q, cnt_d;
    logic           werr_q, werr_d;
    logic [W-1:0]   mem_q [N];
    logic [N-1:0]   valid_q;
    logic           wr0, wr1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        werr_d  = 1'b0;
        wr0     = 1'b0;
        wr1     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    werr_d  = we0_i | we1_i;
                end else begin
                    // Writes to a hardwired r0 are not writes at all: no commit, no collision.
                    wr0    = we0_i && !(ZERO_R0 != 0 && waddr0_i == '0);
                    wr1    = we1_i && !(ZERO_R0 != 0 && waddr1_i == '0);
                    werr_d = wr0 && wr1 && (waddr0_i == waddr1_i);
                end
            end
            ST_SWEEP: begin
                werr_d = we0_i | we1_i;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {A{1'b1}}) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            werr_q  <= werr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
            valid_q <= '0;
        end else begin
            if (state_q == ST_SWEEP) begin
                mem_q[cnt_q]   <= '0;
                valid_q[cnt_q] <= 1'b0;
            end
            if (wr0) begin
                mem_q[waddr0_i]   <= wdata0_i;
                valid_q[waddr0_i] <= 1'b1;
            end
            // Port 1 is applied last so it wins a same-address collision.
            if (wr1) begin
                mem_q[waddr1_i]   <= wdata1_i;
                valid_q[waddr1_i] <= 1'b1;
            end
        end
    end

    // Returns {valid, data}; forwarding only shows writes that will actually commit.
    function automatic logic [W:0] read_port(input logic [A-1:0] ra);
        logic [W:0] r;
        r = {valid_q[ra], mem_q[ra]};
        if (BYPASS != 0) begin
            if (wr1 && waddr1_i == ra)      r = {1'b1, wdata1_i};
            else if (wr0 && waddr0_i == ra) r = {1'b1, wdata0_i};
        end
        if (ZERO_R0 != 0 && ra == '0) r = {1'b1, {W{1'b0}}};
        if (rst_i) r = '0;
        return r;
    endfunction

    always_comb begin
        {rvalid0_o, rdata0_o} = read_port(raddr0_i);
        {rvalid1_o, rdata1_o} = read_port(raddr1_i);
    end

    assign busy_o = (state_q == ST_SWEEP);
    assign werr_o = werr_q;

endmodule
